// File: rtl/seq_mac_explorer_if.sv
// Control/data bundle for seq_mac_explorer: serial operand load, op launch, and status/result.
// The master drives the stimulus side; the slave is the MAC engine.
interface seq_mac_explorer_if #(
  parameter int WIDTH = 8
);
  logic               ena;
  logic               sin_a;
  logic               sin_b;
  logic               shift_en;
  logic               start;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               overflow;

  modport master (
    output ena, sin_a, sin_b, shift_en, start, mode,
    input  busy, done, result, overflow
  );

  modport slave (
    input  ena, sin_a, sin_b, shift_en, start, mode,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/seq_mac_explorer.sv
// Serial-load ADD/MULT/MAC/CLEAR unit: N busy cycles (1 or WIDTH), then a one-cycle done; ena low stalls everything.
// No backpressure: start is ignored unless IDLE. SEQ_MAC_SAT_EN selects a saturating MAC accumulator instead of wrapping.
module seq_mac_explorer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_mac_explorer_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] M_ADD = 2'b00, M_MULT = 2'b01, M_MAC = 2'b10, M_CLR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     result_q, result_d;

  logic [PW-1:0]     addend;
  logic [PW-1:0]     step_sum;
  logic [PW:0]       mac_sum;
  logic              last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= M_ADD;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    // One shift-add step: multiplier consumed LSB first, multiplicand shifted left.
    addend   = mplier_q[0] ? mcand_q : '0;
    step_sum = prod_q + addend;
    mac_sum  = {1'b0, acc_q} + {1'b0, step_sum};
    last     = (op_q == M_MULT || op_q == M_MAC) ? (cnt_q == CW'(WIDTH - 1)) : 1'b1;

    if (bus.ena) begin
      if (bus.shift_en && state_q != S_RUN) begin
        a_d = {a_q[WIDTH-2:0], bus.sin_a};
        b_d = {b_q[WIDTH-2:0], bus.sin_b};
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d  = S_RUN;
            op_d     = bus.mode;
            mcand_d  = {{WIDTH{1'b0}}, a_q};
            mplier_d = b_q;
            prod_d   = '0;
            cnt_d    = '0;
          end
        end
        S_RUN: begin
          prod_d   = step_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (last) begin
            state_d = S_DONE;
            unique case (op_q)
              M_ADD:  result_d = mcand_q + {{WIDTH{1'b0}}, mplier_q};
              M_MULT: result_d = step_sum;
              M_MAC: begin
                ovf_d = ovf_q | mac_sum[PW];
`ifdef SEQ_MAC_SAT_EN
                if (mac_sum[PW]) begin
                  acc_d    = '1;
                  result_d = '1;
                end else begin
                  acc_d    = mac_sum[PW-1:0];
                  result_d = mac_sum[PW-1:0];
                end
`else
                acc_d    = mac_sum[PW-1:0];
                result_d = mac_sum[PW-1:0];
`endif
              end
              M_CLR: begin
                acc_d    = '0;
                ovf_d    = 1'b0;
                result_d = '0;
              end
              default: ;
            endcase
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_mac_explorer.sv
// Scoreboard bench for seq_mac_explorer: a driver pushes arithmetic expectations, a monitor checks each done pulse.
module tb_seq_mac_explorer;
  localparam int W = 8;
  localparam longint PMAX = 64'd1 << (2 * W);
  localparam longint MASK = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_mac_explorer_if #(.WIDTH(W)) bus ();
  seq_mac_explorer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    longint res;
    bit     ovf;
    int     done_cyc;
    int     busy_n;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     busy_cnt = 0;
  longint m_a = 0, m_b = 0, m_acc = 0;
  bit     m_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("overflow", bus.overflow, e.ovf);
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_cycles", busy_cnt, e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("done_timeout_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_overflow", bus.overflow, 0);
    reset = 1'b0;
    m_a = 0; m_b = 0; m_acc = 0; m_ovf = 0;
  endtask

  task automatic shift_in(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.shift_en = 1'b1;
      bus.sin_a = a[i];
      bus.sin_b = b[i];
    end
    @(negedge clk);
    bus.shift_en = 1'b0;
    m_a = a;
    m_b = b;
  endtask

  // Launch one op; the model result is computed from the operands held before any simultaneous shift.
  task automatic run_op(input logic [1:0] md, input bit retrig, input int stall_at,
                        input int stall_len, input bit sh, input bit sa, input bit sbit);
    exp_t   e;
    int     n;
    longint s;
    bit     c;
    n = (md == 2'b01 || md == 2'b10) ? W : 1;
    case (md)
      2'b00: e.res = m_a + m_b;
      2'b01: e.res = m_a * m_b;
      2'b10: begin
        s = m_acc + m_a * m_b;
        c = (s >= PMAX);
`ifdef SEQ_MAC_SAT_EN
        m_acc = c ? PMAX - 1 : s;
`else
        m_acc = s % PMAX;
`endif
        m_ovf = m_ovf | c;
        e.res = m_acc;
      end
      default: begin
        m_acc = 0;
        m_ovf = 0;
        e.res = 0;
      end
    endcase
    e.ovf = m_ovf;
    @(negedge clk);
    e.done_cyc = cyc + 1 + n + stall_len;
    e.busy_n = n + stall_len;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.mode = md;
    if (sh) begin
      bus.shift_en = 1'b1;
      bus.sin_a = sa;
      bus.sin_b = sbit;
      m_a = ((m_a << 1) | longint'(sa)) & MASK;
      m_b = ((m_b << 1) | longint'(sbit)) & MASK;
    end
    @(negedge clk);
    bus.shift_en = 1'b0;
    if (retrig) @(negedge clk);
    bus.start = 1'b0;
    if (stall_len > 0) begin
      repeat (stall_at) @(negedge clk);
      bus.ena = 1'b0;
      repeat (stall_len) @(negedge clk);
      bus.ena = 1'b1;
    end
    wait_idle();
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.sin_a = 1'b0;
    bus.sin_b = 1'b0;
    bus.shift_en = 1'b0;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    apply_reset();

    shift_in(8'hA5, 8'h3C);
    run_op(2'b00, 0, 0, 0, 0, 0, 0);
    shift_in(8'hFF, 8'hFF);
    run_op(2'b01, 1, 0, 0, 0, 0, 0);

    run_op(2'b11, 0, 0, 0, 0, 0, 0);
    shift_in(8'h10, 8'h10);
    repeat (3) run_op(2'b10, 0, 0, 0, 0, 0, 0);

    run_op(2'b11, 0, 0, 0, 0, 0, 0);
    shift_in(8'hFF, 8'hFF);
    run_op(2'b10, 0, 0, 0, 0, 0, 0);
    run_op(2'b10, 0, 0, 0, 0, 0, 0);
    run_op(2'b11, 0, 0, 0, 0, 0, 0);

    run_op(2'b01, 0, 3, 3, 0, 0, 0);

    // Abort a MULT four cycles in; no expectation is queued, so any later done is flagged.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();
    repeat (20) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] md;
      int r, st, sl;
      r = $urandom_range(0, 9);
      md = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 2) != 0) shift_in(W'($urandom), W'($urandom));
      st = 0;
      sl = 0;
      if ((md == 2'b01 || md == 2'b10) && $urandom_range(0, 3) == 0) begin
        st = $urandom_range(0, W - 1);
        sl = $urandom_range(1, 4);
      end
      run_op(md, 0, st, sl, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
